// File: rtl/multiword_adder_sequencer_pkg.sv
// Shared constants for the multiword adder sequencer.
// Slice width and FSM state encoding.
package multiword_adder_sequencer_pkg;
  localparam int SLICE_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/multiword_adder_sequencer_if.sv
// Request/response handshake bundle for the
// multiword adder sequencer.
interface multiword_adder_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             reqValid;
  logic             reqReady;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             sub;
  logic             rspValid;
  logic             rspReady;
  logic [WIDTH-1:0] result;
  logic             cOut;
  logic             overflow;
  logic             busy;

  modport master (
    output reqValid, opA, opB, sub, rspReady,
    input  reqReady, rspValid, result, cOut,
    input  overflow, busy
  );

  modport slave (
    input  reqValid, opA, opB, sub, rspReady,
    output reqReady, rspValid, result, cOut,
    output overflow, busy
  );
endinterface

// File: rtl/multiword_adder_sequencer_cla.sv
// 16-bit carry-lookahead adder slice:
// four 4-bit groups with a group-level lookahead.
module CarryLookAheadAdder16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout,
  output logic        o_pg,
  output logic        o_gg
);
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_pg;
  logic [4:0]  w_cg;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_gg = '0;
    w_pg = '0;
    for (int n = 0; n < 4; n++) begin
      w_pg[n] = &w_p[4*n +: 4];
      w_gg[n] = w_g[4*n+3]
              | (w_p[4*n+3] & w_g[4*n+2])
              | (w_p[4*n+3] & w_p[4*n+2]
                 & w_g[4*n+1])
              | (w_p[4*n+3] & w_p[4*n+2]
                 & w_p[4*n+1] & w_g[4*n]);
    end
  end

  assign w_cg[0] = i_cin;
  assign w_cg[1] = w_gg[0] | (w_pg[0] & i_cin);
  assign w_cg[2] = w_gg[1]
                 | (w_pg[1] & w_gg[0])
                 | (w_pg[1] & w_pg[0] & i_cin);
  assign w_cg[3] = w_gg[2]
                 | (w_pg[2] & w_gg[1])
                 | (w_pg[2] & w_pg[1] & w_gg[0])
                 | (&w_pg[2:0] & i_cin);
  assign w_cg[4] = w_gg[3]
                 | (w_pg[3] & w_gg[2])
                 | (w_pg[3] & w_pg[2] & w_gg[1])
                 | (&w_pg[3:1] & w_gg[0])
                 | (&w_pg & i_cin);

  // Bit carries ripple only within each group.
  always_comb begin
    w_c = '0;
    for (int k = 0; k < 16; k++) begin
      if (k % 4 == 0) w_c[k] = w_cg[k/4];
      else w_c[k] = w_g[k-1] | (w_p[k-1] & w_c[k-1]);
    end
  end

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_cg[4];
  assign o_pg   = &w_pg;
  assign o_gg   = w_gg[3]
                | (w_pg[3] & w_gg[2])
                | (w_pg[3] & w_pg[2] & w_gg[1])
                | (&w_pg[3:1] & w_gg[0]);
endmodule

// File: rtl/multiword_adder_sequencer.sv
// WIDTH-bit add/subtract sequenced through one
// 16-bit CLA slice, LSW first, carry chained in a register.
module multiword_adder_sequencer
  import multiword_adder_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  multiword_adder_sequencer_if.slave bus
);
  localparam int N  = WIDTH / SLICE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_chk
    $error("WIDTH must be a multiple of 16, >= 16");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic [15:0] w_sl_a;
  logic [15:0] w_sl_b;
  logic [15:0] w_sum;
  logic        w_cout;
  logic        w_c15;
  logic        w_last;
  logic        w_unused_pg;
  logic        w_unused_gg;

  always_comb begin
    w_sl_a = '0;
    w_sl_b = '0;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_sl_a = r_a[k*SLICE_W +: SLICE_W];
        w_sl_b = r_b[k*SLICE_W +: SLICE_W];
      end
    end
  end

  CarryLookAheadAdder16 u_cla (
    .i_a    (w_sl_a),
    .i_b    (w_sl_b),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_pg   (w_unused_pg),
    .o_gg   (w_unused_gg)
  );

  assign w_last = (r_idx == IW'(N - 1));
  // Carry into bit 15 recovered from the sum bit.
  assign w_c15  = w_sum[15] ^ w_sl_a[15] ^ w_sl_b[15];

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.reqValid) w_next = ST_RUN;
      ST_RUN:  if (w_last)       w_next = ST_DONE;
      ST_DONE: if (bus.rspReady) w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (bus.reqValid) begin
        r_a     <= bus.opA;
        r_b     <= bus.sub ? ~bus.opB : bus.opB;
        r_carry <= bus.sub;
        r_idx   <= '0;
      end
    end else if (r_state == ST_RUN) begin
      for (int k = 0; k < N; k++) begin
        if (r_idx == IW'(k))
          r_result[k*SLICE_W +: SLICE_W] <= w_sum;
      end
      r_carry <= w_cout;
      if (w_last) begin
        r_cout <= w_cout;
        r_ovf  <= w_c15 ^ w_cout;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.reqReady = (r_state == ST_IDLE);
  assign bus.rspValid = (r_state == ST_DONE);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.result   = r_result;
  assign bus.cOut     = r_cout;
  assign bus.overflow = r_ovf;
endmodule
